nxn_parallel_crossbar: RTL and testbench
========================================

# nxn_parallel_crossbar

Parametrised N×N crossbar for the router switch stage that carries up to PORT_N packets per cycle, one per output, instead of one packet per cycle. Each output has a registered route (source input plus enable) and one registered data stage with valid/ready flow control. Multicast is supported: several outputs may select the same input. The block sits between the input buffers and the output links of a router.

## Interface
- DATA_W, 8, packet width in bits
- PORT_N, 5, number of input ports and number of output ports (≥2)
- SEL_W, $clog2(PORT_N), width of one route select (derived, not overridden)

Ports:
- clk_i  in  1  clock, all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- data_i  in  PORT_N*DATA_W  input packets, port p at [DATA_W*(p+1)-1 : DATA_W*p]
- valid_i  in  PORT_N  per-input valid
- ready_o  out  PORT_N  per-input ready
- cfg_we_i  in  1  route-table write strobe
- cfg_sel_i  in  PORT_N*SEL_W  new source select per output, packed like data_i
- cfg_en_i  in  PORT_N  new route enable per output
- data_o  out  PORT_N*DATA_W  output packets, same packing
- valid_o  out  PORT_N  per-output valid
- ready_i  in  PORT_N  per-output ready from downstream

## Operation
- Route table: per output o, holds `sel[o]` (SEL_W bits) and `en[o]` (1 bit). On cfg_we_i, all entries load in one cycle. New routes apply from the next cycle.
- A cfg_sel_i value ≥ PORT_N forces `en[o]`=0 for that output.
- Output stage o can accept when `!valid_o[o] || ready_i[o]`.
- Input p is *routed* when any output o has `en[o]` && `sel[o]`==p.
- ready_o[p] = routed(p) && every output o routed to p can accept. An unrouted input has ready_o=0.
- A transfer on input p occurs when valid_i[p] && ready_o[p]. All outputs routed to p then load data_i[p] and set valid_o. This makes multicast all-or-nothing.
- Output o clears valid_o[o] when ready_i[o] is high and no new load occurs. A simultaneous drain and load keeps valid_o high with the new data.
- Per-output behaviour is independent. Distinct routes proceed in the same cycle.
- A route-table write does not disturb packets already held in output stages. They drain normally.
- Disabling a route blocks new loads on that output from the next cycle.
- Reset:
  - valid_o=0 and data_o=0.
  - Every en=0 and sel=0, so every ready_o=0.
  - A reset mid-transfer discards all held packets.

## Timing
- Input-to-output latency: 1 cycle. A transfer accepted in cycle t appears on data_o/valid_o in cycle t+1.
- ready_o is combinational from ready_i, valid_o and the route table. There is no combinational path from valid_i to ready_o.
- Full throughput: one packet per cycle per output while ready_i is held high.
- Write timing: a write in cycle t is used by ready_o/loads from cycle t+1.
  - A cycle-t transfer still uses the old route.
- data_o holds its value while valid_o && !ready_i. It is don't-care but stable when valid_o=0.

## Structure
- Shared header/package: SEL_W derivation and packed-bus slice helpers, for reuse by other crossbar variants.
- One sub-module, `xbar_out_stage`: a single-entry valid/ready pipeline register (DATA_W). It is instantiated PORT_N times.
- Top level contains:
  - the route table registers
  - the per-output source muxes
  - the routed/ready reduction per input (a generate loop over outputs)

## Test plan
- Reset, then idle, with PORT_N=5, DATA_W=8 → all valid_o=0, data_o=0, ready_o=5'b00000, even with valid_i=5'b11111.
- Write routes out0←in2, out3←in4 and hold ready_i=all-ones. Drive in2=8'hA5 and in4=8'h3C, valid. → Next cycle: out0=A5, out3=3C, valid_o=5'b01001. Sustained 1 packet/cycle on both.
- Multicast: out1 and out4 ← in0, ready_i[4]=0, valid_o[4]=1. → ready_o[0]=0 and no load on out1. Raise ready_i[4] → in0=8'h77 lands on out1 and out4 in the same cycle.
- Backpressure: out2←in1 and ready_i[2]=0 for 3 cycles after a load of 8'h11. → data_o[2] stays 11, ready_o[1]=0. Release → 11 drains and the next packet follows one cycle later.
- Reconfigure out0 from in2 to in3 while out0 holds 8'h5A. → 5A drains unchanged. ready_o[2] drops and ready_o[3] rises in the cycle after cfg_we_i.
- Invalid select cfg_sel=3'd6 for out1, then rst_i asserted mid-stream. → The invalid select is treated as disabled. After reset: all outputs invalid, all ready_o=0.

Source files
------------

// File: rtl/nxn_parallel_crossbar_pkg.sv
// Shared definitions for the crossbar family: default sizes, route-select width
// derivation and packed-bus lane offset helper.
package nxn_parallel_crossbar_pkg;

   localparam int unsigned XBAR_DATA_W_DEF = 8;
   localparam int unsigned XBAR_PORT_N_DEF = 5;

   // Width of one route select; never below one bit so tiny crossbars still elaborate.
   function automatic int unsigned xbar_sel_w(input int unsigned port_n);
      return (port_n < 2) ? 1 : $clog2(port_n);
   endfunction

   function automatic int unsigned xbar_lane_lo(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/nxn_parallel_crossbar_if.sv
// Data, flow-control and route-configuration bus of the N x N crossbar.
// The slave modport is the crossbar's view; master is the driver's view.
interface nxn_parallel_crossbar_if
   import nxn_parallel_crossbar_pkg::*;
#(
   parameter int unsigned DATA_W = XBAR_DATA_W_DEF,
   parameter int unsigned PORT_N = XBAR_PORT_N_DEF
);
   localparam int unsigned SEL_W = xbar_sel_w(PORT_N);

   logic [PORT_N*DATA_W-1:0] data_i;
   logic [PORT_N-1:0]        valid_i;
   logic [PORT_N-1:0]        ready_o;
   logic                     cfg_we_i;
   logic [PORT_N*SEL_W-1:0]  cfg_sel_i;
   logic [PORT_N-1:0]        cfg_en_i;
   logic [PORT_N*DATA_W-1:0] data_o;
   logic [PORT_N-1:0]        valid_o;
   logic [PORT_N-1:0]        ready_i;

   modport slave (
      input  data_i, valid_i, cfg_we_i, cfg_sel_i, cfg_en_i, ready_i,
      output ready_o, data_o, valid_o
   );

   modport master (
      output data_i, valid_i, cfg_we_i, cfg_sel_i, cfg_en_i, ready_i,
      input  ready_o, data_o, valid_o
   );

endinterface

// File: rtl/nxn_parallel_crossbar_xbar_out_stage.sv
// Single-entry valid/ready pipeline register feeding one crossbar output link.
module xbar_out_stage #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_can_accept
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // Data only changes on a load, so it is stable while stalled or empty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid      = r_valid;
   assign o_data       = r_data;
   assign o_can_accept = !r_valid || i_ready;

endmodule

// File: rtl/nxn_parallel_crossbar.sv
// N x N crossbar with per-output registered route table and output stage;
// one packet per output per cycle, multicast loads are all-or-nothing.
module nxn_parallel_crossbar
   import nxn_parallel_crossbar_pkg::*;
#(
   parameter int unsigned DATA_W = XBAR_DATA_W_DEF,
   parameter int unsigned PORT_N = XBAR_PORT_N_DEF
) (
   input logic                  clk_i,
   input logic                  rst_i,
   nxn_parallel_crossbar_if.slave bus
);

   localparam int unsigned SEL_W = xbar_sel_w(PORT_N);

   logic [SEL_W-1:0]                r_sel [PORT_N];
   logic [PORT_N-1:0]               r_en;

   logic [PORT_N-1:0][PORT_N-1:0]   w_hit;
   logic [PORT_N-1:0]               w_can_acc;
   logic [PORT_N-1:0]               w_routed;
   logic [PORT_N-1:0]               w_blocked;
   logic [PORT_N-1:0]               w_ready;
   logic [PORT_N-1:0]               w_xfer;
   logic [PORT_N-1:0]               w_load;
   logic [PORT_N-1:0]               w_valid;
   logic [PORT_N*DATA_W-1:0]        w_data;

   // Out-of-range selects are stored disabled so they can never match an input.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned o = 0; o < PORT_N; o++) begin
            r_sel[o] <= '0;
         end
         r_en <= '0;
      end else if (bus.cfg_we_i) begin
         for (int unsigned o = 0; o < PORT_N; o++) begin
            r_sel[o] <= bus.cfg_sel_i[xbar_lane_lo(o, SEL_W) +: SEL_W];
            r_en[o]  <= bus.cfg_en_i[o]
                        && (32'(bus.cfg_sel_i[xbar_lane_lo(o, SEL_W) +: SEL_W]) < PORT_N);
         end
      end
   end

   always_comb begin
      w_routed  = '0;
      w_blocked = '0;
      for (int unsigned p = 0; p < PORT_N; p++) begin
         for (int unsigned o = 0; o < PORT_N; o++) begin
            w_routed[p]  = w_routed[p]  | w_hit[o][p];
            w_blocked[p] = w_blocked[p] | (w_hit[o][p] & ~w_can_acc[o]);
         end
      end
   end

   assign w_ready = w_routed & ~w_blocked;
   assign w_xfer  = bus.valid_i & w_ready;

   for (genvar o = 0; o < PORT_N; o++) begin : g_out
      logic [DATA_W-1:0] w_src_data;

      for (genvar p = 0; p < PORT_N; p++) begin : g_hit
         assign w_hit[o][p] = r_en[o] && (r_sel[o] == SEL_W'(p));
      end

      always_comb begin
         w_src_data = '0;
         for (int unsigned p = 0; p < PORT_N; p++) begin
            if (r_sel[o] == SEL_W'(p)) begin
               w_src_data = bus.data_i[xbar_lane_lo(p, DATA_W) +: DATA_W];
            end
         end
      end

      // w_hit row is one-hot or zero, so this picks the routed input's transfer.
      assign w_load[o] = |(w_hit[o] & w_xfer);

      xbar_out_stage #(
         .DATA_W(DATA_W)
      ) u_stage (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .i_load       (w_load[o]),
         .i_data       (w_src_data),
         .i_ready      (bus.ready_i[o]),
         .o_valid      (w_valid[o]),
         .o_data       (w_data[xbar_lane_lo(o, DATA_W) +: DATA_W]),
         .o_can_accept (w_can_acc[o])
      );
   end

   assign bus.ready_o = w_ready;
   assign bus.valid_o = w_valid;
   assign bus.data_o  = w_data;

endmodule

// File: tb/tb_nxn_parallel_crossbar.sv
// Directed self-checking bench for nxn_parallel_crossbar (PORT_N=5, DATA_W=8).
module tb_nxn_parallel_crossbar;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   nxn_parallel_crossbar_if #(.DATA_W(8), .PORT_N(5)) bus ();

   nxn_parallel_crossbar #(.DATA_W(8), .PORT_N(5)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] lane(input logic [39:0] v, input int p);
      return v[p*8 +: 8];
   endfunction

   function automatic logic [14:0] sel_bus(input logic [2:0] s0, input logic [2:0] s1,
                                           input logic [2:0] s2, input logic [2:0] s3,
                                           input logic [2:0] s4);
      return {s4, s3, s2, s1, s0};
   endfunction

   task automatic set_in(input int p, input logic [7:0] d);
      bus.data_i[p*8 +: 8] = d;
   endtask

   task automatic cfg_write(input logic [14:0] sb, input logic [4:0] eb);
      bus.cfg_sel_i = sb;
      bus.cfg_en_i  = eb;
      bus.cfg_we_i  = 1'b1;
      step();
      bus.cfg_we_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.valid_i = 5'b11111;
      bus.data_i  = 40'hFFFF_FFFF_FF;
      bus.ready_i = 5'b11111;
      step();
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000) begin
         $display("FAIL reset_valid got=%b exp=%b", bus.valid_o, 5'b00000); n_fail++;
      end
      n_checks++;
      if (bus.data_o !== 40'h0) begin
         $display("FAIL reset_data got=%h exp=%h", bus.data_o, 40'h0); n_fail++;
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b00000) begin
         $display("FAIL reset_ready got=%b exp=%b", bus.ready_o, 5'b00000); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000 || bus.data_o !== 40'h0) begin
         $display("FAIL idle_out got=%b/%h exp=00000/0", bus.valid_o, bus.data_o); n_fail++;
      end
   endtask

   task automatic test_unicast();
      bus.valid_i = '0;
      bus.ready_i = 5'b11111;
      cfg_write(sel_bus(3'd2, 3'd0, 3'd0, 3'd4, 3'd0), 5'b01001);
      set_in(2, 8'hA5);
      set_in(4, 8'h3C);
      bus.valid_i = 5'b10100;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b10100) begin
         $display("FAIL uni_ready got=%b exp=%b", bus.ready_o, 5'b10100); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b01001 || lane(bus.data_o, 0) !== 8'hA5 || lane(bus.data_o, 3) !== 8'h3C) begin
         $display("FAIL uni_first got=%b/%h/%h exp=01001/a5/3c",
                  bus.valid_o, lane(bus.data_o, 0), lane(bus.data_o, 3)); n_fail++;
      end
      for (int k = 1; k <= 3; k++) begin
         set_in(2, 8'hA5 + 8'(k));
         set_in(4, 8'h3C + 8'(k));
         step();
         n_checks++;
         if (bus.valid_o !== 5'b01001 || lane(bus.data_o, 0) !== 8'hA5 + 8'(k)
             || lane(bus.data_o, 3) !== 8'h3C + 8'(k)) begin
            $display("FAIL back_to_back k=%0d got=%b/%h/%h exp=01001/%h/%h", k, bus.valid_o,
                     lane(bus.data_o, 0), lane(bus.data_o, 3), 8'hA5 + 8'(k), 8'h3C + 8'(k));
            n_fail++;
         end
      end
      bus.valid_i = '0;
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000) begin
         $display("FAIL uni_drain got=%b exp=%b", bus.valid_o, 5'b00000); n_fail++;
      end
   endtask

   task automatic test_multicast();
      bus.ready_i = 5'b11111;
      cfg_write(sel_bus(3'd0, 3'd0, 3'd0, 3'd0, 3'd0), 5'b10010);
      set_in(0, 8'h66);
      bus.valid_i = 5'b00001;
      step();
      n_checks++;
      if (bus.valid_o !== 5'b10010 || lane(bus.data_o, 1) !== 8'h66 || lane(bus.data_o, 4) !== 8'h66) begin
         $display("FAIL mc_first got=%b/%h/%h exp=10010/66/66",
                  bus.valid_o, lane(bus.data_o, 1), lane(bus.data_o, 4)); n_fail++;
      end
      bus.ready_i = 5'b01111;
      set_in(0, 8'h77);
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b00000) begin
         $display("FAIL mc_blocked_ready got=%b exp=%b", bus.ready_o, 5'b00000); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b10000 || lane(bus.data_o, 4) !== 8'h66) begin
         $display("FAIL mc_no_load got=%b/%h exp=10000/66", bus.valid_o, lane(bus.data_o, 4)); n_fail++;
      end
      bus.ready_i = 5'b11111;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b00001) begin
         $display("FAIL mc_release_ready got=%b exp=%b", bus.ready_o, 5'b00001); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b10010 || lane(bus.data_o, 1) !== 8'h77 || lane(bus.data_o, 4) !== 8'h77) begin
         $display("FAIL mc_both got=%b/%h/%h exp=10010/77/77",
                  bus.valid_o, lane(bus.data_o, 1), lane(bus.data_o, 4)); n_fail++;
      end
      bus.valid_i = '0;
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000) begin
         $display("FAIL mc_drain got=%b exp=%b", bus.valid_o, 5'b00000); n_fail++;
      end
   endtask

   task automatic test_backpressure();
      bus.ready_i = 5'b11111;
      cfg_write(sel_bus(3'd0, 3'd0, 3'd1, 3'd0, 3'd0), 5'b00100);
      set_in(1, 8'h11);
      bus.valid_i = 5'b00010;
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00100 || lane(bus.data_o, 2) !== 8'h11) begin
         $display("FAIL bp_load got=%b/%h exp=00100/11", bus.valid_o, lane(bus.data_o, 2)); n_fail++;
      end
      bus.ready_i = 5'b11011;
      set_in(1, 8'h22);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (bus.ready_o !== 5'b00000) begin
            $display("FAIL bp_ready k=%0d got=%b exp=%b", k, bus.ready_o, 5'b00000); n_fail++;
         end
         step();
         n_checks++;
         if (bus.valid_o !== 5'b00100 || lane(bus.data_o, 2) !== 8'h11) begin
            $display("FAIL bp_hold k=%0d got=%b/%h exp=00100/11", k, bus.valid_o, lane(bus.data_o, 2));
            n_fail++;
         end
      end
      bus.ready_i = 5'b11111;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b00010) begin
         $display("FAIL bp_release_ready got=%b exp=%b", bus.ready_o, 5'b00010); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00100 || lane(bus.data_o, 2) !== 8'h22) begin
         $display("FAIL bp_next got=%b/%h exp=00100/22", bus.valid_o, lane(bus.data_o, 2)); n_fail++;
      end
      bus.valid_i = '0;
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000) begin
         $display("FAIL bp_drain got=%b exp=%b", bus.valid_o, 5'b00000); n_fail++;
      end
   endtask

   task automatic test_reconfig();
      bus.ready_i = 5'b00000;
      cfg_write(sel_bus(3'd2, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00001);
      set_in(2, 8'h5A);
      set_in(3, 8'hC3);
      bus.valid_i = 5'b00100;
      step();
      bus.valid_i = 5'b00000;
      n_checks++;
      if (bus.valid_o !== 5'b00001 || lane(bus.data_o, 0) !== 8'h5A) begin
         $display("FAIL rc_load got=%b/%h exp=00001/5a", bus.valid_o, lane(bus.data_o, 0)); n_fail++;
      end
      bus.ready_i = 5'b00001;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b00100) begin
         $display("FAIL rc_old_route got=%b exp=%b", bus.ready_o, 5'b00100); n_fail++;
      end
      bus.ready_i = 5'b00000;
      cfg_write(sel_bus(3'd3, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00001);
      #1;
      n_checks++;
      if (bus.valid_o !== 5'b00001 || lane(bus.data_o, 0) !== 8'h5A || bus.ready_o !== 5'b00000) begin
         $display("FAIL rc_held got=%b/%h/%b exp=00001/5a/00000",
                  bus.valid_o, lane(bus.data_o, 0), bus.ready_o); n_fail++;
      end
      bus.ready_i = 5'b00001;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b01000) begin
         $display("FAIL rc_new_route got=%b exp=%b", bus.ready_o, 5'b01000); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000) begin
         $display("FAIL rc_drain got=%b exp=%b", bus.valid_o, 5'b00000); n_fail++;
      end
   endtask

   task automatic test_invalid_sel_reset();
      bus.ready_i = 5'b11111;
      cfg_write(sel_bus(3'd2, 3'd6, 3'd0, 3'd0, 3'd0), 5'b00011);
      bus.data_i  = 40'h14_13_12_11_10;
      bus.valid_i = 5'b11111;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b00100) begin
         $display("FAIL inv_ready got=%b exp=%b", bus.ready_o, 5'b00100); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00001 || lane(bus.data_o, 0) !== 8'h12) begin
         $display("FAIL inv_load got=%b/%h exp=00001/12", bus.valid_o, lane(bus.data_o, 0)); n_fail++;
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000 || bus.data_o !== 40'h0 || bus.ready_o !== 5'b00000) begin
         $display("FAIL midrst got=%b/%h/%b exp=00000/0/00000", bus.valid_o, bus.data_o, bus.ready_o);
         n_fail++;
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.ready_o !== 5'b00000) begin
         $display("FAIL postrst_ready got=%b exp=%b", bus.ready_o, 5'b00000); n_fail++;
      end
      step();
      n_checks++;
      if (bus.valid_o !== 5'b00000) begin
         $display("FAIL postrst_valid got=%b exp=%b", bus.valid_o, 5'b00000); n_fail++;
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.cfg_we_i  = 1'b0;
      bus.cfg_sel_i = '0;
      bus.cfg_en_i  = '0;
      bus.data_i    = '0;
      bus.valid_i   = '0;
      bus.ready_i   = '0;
      test_reset();
      test_unicast();
      test_multicast();
      test_backpressure();
      test_reconfig();
      test_invalid_sel_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
